// File: rtl/midi_pkg.sv
// Shared encodings, FSM state type and helpers for the MIDI transmit path.
package midi_pkg;

    localparam logic [1:0] KIND_NOTE_OFF = 2'b00;
    localparam logic [1:0] KIND_NOTE_ON  = 2'b01;
    localparam logic [1:0] KIND_CC       = 2'b10;
    localparam logic [1:0] KIND_RSVD     = 2'b11;

    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [3:0] STATUS_CC       = 4'hB;

    // Index of the stop bit within a 10-bit 8N1 frame.
    localparam int unsigned FRAME_LAST_BIT = 9;

    typedef enum logic [1:0] {
        StIdle,
        StSendStatus,
        StSendData0,
        StSendData1
    } msg_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic logic [7:0] status_byte(input logic [1:0] kind,
                                               input logic [3:0] channel);
        logic [3:0] nibble;
        case (kind)
            KIND_NOTE_ON: nibble = STATUS_NOTE_ON;
            KIND_CC:      nibble = STATUS_CC;
            default:      nibble = STATUS_NOTE_OFF;
        endcase
        return {nibble, channel};
    endfunction

endpackage

// File: rtl/midi_byte_writer.sv
// 8N1 UART transmitter. The line register trails the frame counters by one cycle, so
// a byte handed over on edge e drives its start bit from edge e+1.
module midi_byte_writer
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1600
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_value,
    output logic       byte_done,
    output logic       tx
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CntW-1:0] baud_cnt_q;
    logic [3:0]      bit_idx_q;
    logic [9:0]      frame_q;
    logic            active_q;
    logic            tx_q;
    logic            done_q;

    logic bit_end;
    logic last_cycle;
    logic load;

    assign bit_end    = baud_cnt_q == CntW'(CLKS_PER_BIT - 1);
    assign last_cycle = active_q && bit_end && (bit_idx_q == 4'(FRAME_LAST_BIT));
    // Ready in the final stop-bit cycle so consecutive bytes leave with no idle gap.
    assign byte_ready = !active_q || last_cycle;
    assign load       = byte_valid && byte_ready;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            active_q   <= 1'b0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '1;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_cycle;
            tx_q   <= active_q ? frame_q[bit_idx_q] : 1'b1;
            if (load) begin
                active_q   <= 1'b1;
                baud_cnt_q <= '0;
                bit_idx_q  <= '0;
                frame_q    <= {1'b1, byte_value, 1'b0};
            end else if (active_q) begin
                if (bit_end) begin
                    baud_cnt_q <= '0;
                    if (bit_idx_q == 4'(FRAME_LAST_BIT)) begin
                        active_q <= 1'b0;
                    end else begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                    end
                end else begin
                    baud_cnt_q <= baud_cnt_q + CntW'(1);
                end
            end
        end
    end

    assign tx        = tx_q;
    assign byte_done = done_q;

endmodule

// File: rtl/midi_event_transmitter.sv
// Formats Note Off / Note On / Control Change events as 3-byte MIDI messages with
// optional running status and streams them out through the byte writer.
module midi_event_transmitter
    import midi_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned BAUD           = 31250,
    parameter bit          RUNNING_STATUS = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       event_valid,
    output logic       event_ready,
    input  logic [1:0] event_kind,
    input  logic [3:0] event_channel,
    input  logic [6:0] event_data0,
    input  logic [6:0] event_data1,
    output logic       MIDI_TX,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    msg_state_e state_q, state_d;

    logic [7:0] status_q;
    logic [7:0] data0_q;
    logic [7:0] data1_q;
    logic [7:0] last_status_q;
    logic       rs_valid_q;
    logic       status_pending_q;
    logic       data1_sent_q;
    logic       ready_q;

    logic       accept;
    logic       skip_status;
    logic       handoff;
    logic [7:0] event_status;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_done;
    logic [7:0] byte_value;

    assign accept       = event_valid && ready_q;
    assign event_status = status_byte(event_kind, event_channel);
    assign skip_status  = RUNNING_STATUS && rs_valid_q && (event_status == last_status_q);
    assign handoff      = byte_valid && byte_ready;
    assign event_ready  = ready_q;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (event_kind != KIND_RSVD)) begin
                    state_d = skip_status ? StSendData0 : StSendStatus;
                end
            end
            StSendStatus: begin
                if (handoff) state_d = StSendData0;
            end
            StSendData0: begin
                if (handoff) state_d = StSendData1;
            end
            StSendData1: begin
                // Writer idle right after a stop bit means the last byte has left the pin.
                if (data1_sent_q && byte_done && byte_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_value = data0_q;
        busy       = 1'b1;
        unique case (state_q)
            StIdle: busy = 1'b0;
            StSendStatus: begin
                byte_valid = 1'b1;
                byte_value = status_q;
            end
            StSendData0: begin
                byte_valid = 1'b1;
                byte_value = data0_q;
            end
            StSendData1: begin
                byte_valid = !data1_sent_q;
                byte_value = data1_q;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            ready_q          <= 1'b0;
            status_q         <= '0;
            data0_q          <= '0;
            data1_q          <= '0;
            last_status_q    <= '0;
            rs_valid_q       <= 1'b0;
            status_pending_q <= 1'b0;
            data1_sent_q     <= 1'b0;
        end else begin
            // A discarded reserved event still drops ready for exactly one cycle.
            ready_q <= (state_d == StIdle) && !accept;
            if (accept) begin
                status_q <= event_status;
                data0_q  <= {1'b0, event_data0};
                data1_q  <= {1'b0, event_data1};
            end
            // The first byte completion after handing over a status byte is that status byte.
            if ((state_q == StSendStatus) && handoff) begin
                status_pending_q <= 1'b1;
            end else if (byte_done) begin
                status_pending_q <= 1'b0;
            end
            if (status_pending_q && byte_done) begin
                last_status_q <= status_q;
                rs_valid_q    <= 1'b1;
            end
            if ((state_q == StSendData1) && handoff) begin
                data1_sent_q <= 1'b1;
            end else if (state_q == StIdle) begin
                data1_sent_q <= 1'b0;
            end
        end
    end

    midi_byte_writer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_writer (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_value(byte_value),
        .byte_done (byte_done),
        .tx        (MIDI_TX)
    );

endmodule

// File: tb/tb_midi_event_transmitter.sv
// Self-checking bench: table of events with expected bytes fed to a scoreboard queue,
// a line monitor decoding MIDI_TX, and hand-written reset / hold / reserved sequences.
module tb_midi_event_transmitter;
    import midi_pkg::*;

    localparam int unsigned CLK_HZ    = 500_000;
    localparam int unsigned BAUD      = 31250;
    localparam int unsigned CPB       = CLK_HZ / BAUD;
    localparam int unsigned MSG_BOUND = 40 * CPB;
    localparam int unsigned NVEC      = 6;

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  ch;
        logic [6:0]  d0;
        logic [6:0]  d1;
        int          nbytes;
        logic [23:0] bytes;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RESET;
    logic       event_valid;
    logic       event_ready;
    logic [1:0] event_kind;
    logic [3:0] event_channel;
    logic [6:0] event_data0;
    logic [6:0] event_data1;
    logic       MIDI_TX;
    logic       busy;

    logic       ev2_valid;
    logic       ev2_ready;
    logic [1:0] ev2_kind;
    logic [3:0] ev2_channel;
    logic [6:0] ev2_data0;
    logic [6:0] ev2_data1;
    logic       tx2;
    logic       busy2;

    midi_event_transmitter #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(1'b1)
    ) dut (
        .CLOCK_50(clk), .RESET(RESET), .event_valid(event_valid), .event_ready(event_ready),
        .event_kind(event_kind), .event_channel(event_channel), .event_data0(event_data0),
        .event_data1(event_data1), .MIDI_TX(MIDI_TX), .busy(busy)
    );

    midi_event_transmitter #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(1'b0)
    ) dut_nors (
        .CLOCK_50(clk), .RESET(RESET), .event_valid(ev2_valid), .event_ready(ev2_ready),
        .event_kind(ev2_kind), .event_channel(ev2_channel), .event_data0(ev2_data0),
        .event_data1(ev2_data1), .MIDI_TX(tx2), .busy(busy2)
    );

    int          checks   = 0;
    int          failures = 0;
    longint      cyc      = 0;
    logic [7:0]  exp_q[$];
    logic        drop_frame = 1'b0;
    vec_t        vecs[NVEC];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: decode each frame at mid-bit and compare with the scoreboard.
    initial begin : monitor
        logic [7:0] b;
        logic       sb;
        logic       pb;
        forever begin
            @(negedge MIDI_TX);
            repeat (CPB / 2) @(posedge clk);
            #1 sb = MIDI_TX;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = MIDI_TX;
            end
            repeat (CPB) @(posedge clk);
            #1 pb = MIDI_TX;
            if (!drop_frame) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected none", b);
                end else begin
                    check("line_byte", {22'd0, sb, pb, b}, {22'd0, 1'b0, 1'b1, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic accept_event(input logic [1:0] k, input logic [3:0] ch,
                                input logic [6:0] d0, input logic [6:0] d1,
                                input bit keep, output longint t);
        int n = 0;
        event_kind    = k;
        event_channel = ch;
        event_data0   = d0;
        event_data1   = d1;
        event_valid   = 1'b1;
        while (!event_ready && n < MSG_BOUND) begin
            @(posedge clk);
            #1 n++;
        end
        check("ready_before_accept", {31'd0, event_ready}, 32'd1);
        @(posedge clk);
        #1 t = cyc;
        if (!keep) event_valid = 1'b0;
    endtask

    task automatic finish_msg(input longint t, input int nbytes, input int left);
        int   n    = 0;
        logic leak = 1'b0;
        check("accept_drops_ready", {31'd0, event_ready}, 32'd0);
        check("accept_raises_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 check("tx_idle_at_k1", {31'd0, MIDI_TX}, 32'd1);
        @(posedge clk);
        #1 check("tx_start_at_k2", {31'd0, MIDI_TX}, 32'd0);
        while (busy && n < MSG_BOUND) begin
            if (event_ready) leak = 1'b1;
            @(posedge clk);
            #1 n++;
        end
        check("busy_length", 32'(cyc - t), 32'(2 + nbytes * 10 * CPB));
        check("ready_during_busy", {31'd0, leak}, 32'd0);
        check("ready_at_end", {31'd0, event_ready}, 32'd1);
        check("bytes_left", 32'(exp_q.size()), 32'(left));
    endtask

    task automatic push_bytes(input logic [23:0] bytes, input int nbytes);
        for (int j = 0; j < nbytes; j++) exp_q.push_back(bytes[23 - 8 * j -: 8]);
    endtask

    task automatic send_nors(input logic [6:0] d0, input logic [6:0] d1,
                             output logic [9:0] frame, output longint len);
        int     n = 0;
        longint t;
        ev2_kind    = KIND_NOTE_ON;
        ev2_channel = 4'd0;
        ev2_data0   = d0;
        ev2_data1   = d1;
        ev2_valid   = 1'b1;
        while (!ev2_ready && n < MSG_BOUND) begin
            @(posedge clk);
            #1 n++;
        end
        @(posedge clk);
        #1 t = cyc;
        ev2_valid = 1'b0;
        repeat (2 + CPB / 2) @(posedge clk);
        #1 frame[0] = tx2;
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(posedge clk);
            #1 frame[i] = tx2;
        end
        n = 0;
        while (busy2 && n < MSG_BOUND) begin
            @(posedge clk);
            #1 n++;
        end
        len = cyc - t;
    endtask

    initial begin : main
        longint     t;
        logic       leak;
        logic [9:0] frame;
        longint     len;

        RESET = 1'b1;
        event_valid = 1'b0; event_kind = '0; event_channel = '0;
        event_data0 = '0; event_data1 = '0;
        ev2_valid = 1'b0; ev2_kind = '0; ev2_channel = '0; ev2_data0 = '0; ev2_data1 = '0;

        vecs[0] = '{KIND_NOTE_ON,  4'd0, 7'd60, 7'd100, 3, 24'h903C64};
        vecs[1] = '{KIND_NOTE_ON,  4'd0, 7'd62, 7'd100, 2, 24'h3E6400};
        vecs[2] = '{KIND_NOTE_OFF, 4'd3, 7'd60, 7'd0,   3, 24'h833C00};
        vecs[3] = '{KIND_CC,       4'd0, 7'd1,  7'd64,  3, 24'hB00140};
        vecs[4] = '{KIND_NOTE_ON,  4'd0, 7'd5,  7'd7,   3, 24'h900507};
        vecs[5] = '{KIND_NOTE_ON,  4'd0, 7'd5,  7'd8,   2, 24'h050800};

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'd0, MIDI_TX}, 32'd1);
        check("reset_ready", {31'd0, event_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        RESET = 1'b0;
        @(posedge clk);
        #1 check("ready_first_edge", {31'd0, event_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            push_bytes(vecs[i].bytes, vecs[i].nbytes);
            accept_event(vecs[i].kind, vecs[i].ch, vecs[i].d0, vecs[i].d1, 1'b0, t);
            finish_msg(t, vecs[i].nbytes, 0);
        end

        // event_valid held through the message: second accept only once ready returns.
        push_bytes(24'hB00140, 3);
        push_bytes(24'h014000, 2);
        accept_event(KIND_CC, 4'd0, 7'd1, 7'd64, 1'b1, t);
        finish_msg(t, 3, 2);
        @(posedge clk);
        #1 t = cyc;
        event_valid = 1'b0;
        finish_msg(t, 2, 0);

        // Reserved kind: swallowed, no line activity, running status kept.
        accept_event(KIND_RSVD, 4'd0, 7'd9, 7'd9, 1'b0, t);
        check("rsvd_ready_low", {31'd0, event_ready}, 32'd0);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        leak = 1'b0;
        @(posedge clk);
        #1 check("rsvd_ready_back", {31'd0, event_ready}, 32'd1);
        for (int i = 0; i < 3 * CPB; i++) begin
            if (!MIDI_TX || busy) leak = 1'b1;
            @(posedge clk);
            #1;
        end
        check("rsvd_line_quiet", {31'd0, leak}, 32'd0);
        push_bytes(24'h014100, 2);
        accept_event(KIND_CC, 4'd0, 7'd1, 7'd65, 1'b0, t);
        finish_msg(t, 2, 0);

        // Reset in the middle of a data bit of the second byte on the line.
        push_bytes(24'h900A14, 3);
        accept_event(KIND_NOTE_ON, 4'd0, 7'd10, 7'd20, 1'b0, t);
        finish_msg(t, 3, 0);
        exp_q.push_back(8'h0B);
        accept_event(KIND_NOTE_ON, 4'd0, 7'd11, 7'd21, 1'b0, t);
        repeat (2 + 14 * CPB + CPB / 2 - 1) @(posedge clk);
        #1;
        RESET = 1'b1;
        drop_frame = 1'b1;
        event_kind = KIND_NOTE_ON; event_channel = 4'd0;
        event_data0 = 7'd12; event_data1 = 7'd22;
        event_valid = 1'b1;
        @(posedge clk);
        #1 check("reset_mid_tx", {31'd0, MIDI_TX}, 32'd1);
        check("reset_mid_busy", {31'd0, busy}, 32'd0);
        leak = 1'b0;
        for (int i = 0; i < 8 * CPB; i++) begin
            if (event_ready || busy || !MIDI_TX) leak = 1'b1;
            @(posedge clk);
            #1;
        end
        check("reset_hold_quiet", {31'd0, leak}, 32'd0);
        check("reset_scoreboard", 32'(exp_q.size()), 32'd0);
        drop_frame = 1'b0;
        RESET = 1'b0;
        @(posedge clk);
        #1 check("ready_after_release", {31'd0, event_ready}, 32'd1);
        check("no_accept_in_reset", {31'd0, busy}, 32'd0);
        push_bytes(24'h900C16, 3);
        accept_event(KIND_NOTE_ON, 4'd0, 7'd12, 7'd22, 1'b0, t);
        finish_msg(t, 3, 0);

        // Running status disabled: repeated status is always sent.
        send_nors(7'd60, 7'd100, frame, len);
        check("nors_first_frame", {22'd0, frame}, {22'd0, 1'b1, 8'h90, 1'b0});
        check("nors_first_len", 32'(len), 32'(2 + 30 * CPB));
        send_nors(7'd62, 7'd100, frame, len);
        check("nors_repeat_frame", {22'd0, frame}, {22'd0, 1'b1, 8'h90, 1'b0});
        check("nors_repeat_len", 32'(len), 32'(2 + 30 * CPB));

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
